mult_div_unit: RTL and testbench

Iterative multiply/divide engine that produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. It sits in the execute stage, is launched by a single-cycle start, and stalls the pipeline through `mult_busy`. On completion it drives the HI/LO register's write port (`reg_file_mult_data_low`/`_high`/`_write`) with a one-cycle write pulse.

---
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
// Iterative MULT/MULTU/DIV/DIVU engine producing the HI/LO pair for the execute stage.
// Latency: 34 cycles start-to-write-strobe (2 for multiplies when MULT_DIV_FAST_MULT_EN is defined).
// Backpressure: none accepted; mult_busy stalls the pipeline and starts while busy are dropped.
//
// Optional feature macro: MULT_DIV_FAST_MULT_EN (single-cycle 32x32 multiplier for MULT/MULTU).
//
// Ports:
//   clk, rst                  - rising-edge clock, asynchronous active-low reset
//   mult_start, mult_op       - launch pulse and op select (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   mult_src_a, mult_src_b    - rs / rt operands (dividend / divisor for divides)
//   mult_busy                 - high while an operation is in flight
//   reg_file_mult_data_low    - LO result (product low half or quotient)
//   reg_file_mult_data_high   - HI result (product high half or remainder)
//   reg_file_mult_write       - one-cycle HI/LO write strobe
module mult_div_unit #(
  parameter int DATA_32_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mult_start,
  input  logic [1:0]           mult_op,
  input  logic [DATA_32_W-1:0] mult_src_a,
  input  logic [DATA_32_W-1:0] mult_src_b,
  output logic                 mult_busy,
  output logic [DATA_32_W-1:0] reg_file_mult_data_low,
  output logic [DATA_32_W-1:0] reg_file_mult_data_high,
  output logic                 reg_file_mult_write
);

  localparam int W = DATA_32_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state_q,    state_d;
  logic [5:0]     cnt_q,      cnt_d;
  logic           is_div_q,   is_div_d;
  logic           neg_res_q,  neg_res_d;   // operand signs differ
  logic           neg_rem_q,  neg_rem_d;   // dividend was negative
  logic           div_zero_q, div_zero_d;
  logic [W-1:0]   opb_q,      opb_d;       // multiplicand / divisor magnitude
  logic [2*W-1:0] acc_q,      acc_d;       // {hi, lo}: {product} or {rem, quo}
  logic [W-1:0]   lo_q,       lo_d;
  logic [W-1:0]   hi_q,       hi_d;
  logic           write_q,    write_d;

  // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  logic           is_signed_op;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;

  // One shift-add multiply step and one restoring divide step on the accumulator.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_rem_sh;
  logic           div_ge;
  logic [W:0]     div_rem_new;
  logic [2*W-1:0] div_next;

  // Sign-corrected results presented in FIX.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_signed_op = ~mult_op[0];
    a_neg        = is_signed_op & mult_src_a[W-1];
    b_neg        = is_signed_op & mult_src_b[W-1];
    a_mag        = a_neg ? -mult_src_a : mult_src_a;
    b_mag        = b_neg ? -mult_src_b : mult_src_b;

    mul_sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    mul_next     = {mul_sum, acc_q[W-1:1]};

    // The remainder needs W+1 bits after the shift since rem < divisor before it.
    div_rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge       = (div_rem_sh >= {1'b0, opb_q});
    div_rem_new  = div_ge ? (div_rem_sh - {1'b0, opb_q}) : div_rem_sh;
    div_next     = {div_rem_new[W-1:0], acc_q[W-2:0], div_ge};

    prod_fix     = neg_res_q ? -acc_q : acc_q;
    // A zero divisor yields an all-ones quotient magnitude; keep it unsigned so LO stays all ones.
    quo_fix      = (neg_res_q & ~div_zero_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix      = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    write_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          is_div_d   = mult_op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (mult_src_b == {W{1'b0}});
          cnt_d      = 6'd0;
          // Same load for both ops: hi = 0, lo = multiplier / dividend.
          acc_d      = {{W{1'b0}}, a_mag};
          opb_d      = b_mag;
`ifdef MULT_DIV_FAST_MULT_EN
          if (!mult_op[1]) begin
            acc_d   = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
`else
          state_d    = S_ITER;
`endif
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[W-1:0];
          hi_d = prod_fix[2*W-1:W];
        end
        write_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opb_q      <= {W{1'b0}};
      acc_q      <= {(2*W){1'b0}};
      lo_q       <= {W{1'b0}};
      hi_q       <= {W{1'b0}};
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      write_q    <= write_d;
    end
  end

  assign mult_busy               = (state_q != S_IDLE);
  assign reg_file_mult_data_low  = lo_q;
  assign reg_file_mult_data_high = hi_q;
  assign reg_file_mult_write     = write_q;

endmodule

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
// Bench for mult_div_unit: scoreboard of expected {HI,LO} pairs, latency/busy profile checks,
// ignored-start and mid-operation reset scenarios. Build with MULT_DIV_FAST_MULT_EN to match a fast DUT.
module tb_mult_div_unit;

  localparam int LAT_DIV = 34;
`ifdef MULT_DIV_FAST_MULT_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 34;
`endif

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_start = 1'b0;
  logic [1:0]  mult_op = 2'b00;
  logic [31:0] mult_src_a = 32'd0;
  logic [31:0] mult_src_b = 32'd0;
  logic        mult_busy;
  logic [31:0] reg_file_mult_data_low;
  logic [31:0] reg_file_mult_data_high;
  logic        reg_file_mult_write;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .mult_start              (mult_start),
    .mult_op                 (mult_op),
    .mult_src_a              (mult_src_a),
    .mult_src_b              (mult_src_b),
    .mult_busy               (mult_busy),
    .reg_file_mult_data_low  (reg_file_mult_data_low),
    .reg_file_mult_data_high (reg_file_mult_data_high),
    .reg_file_mult_write     (reg_file_mult_write)
  );

  always #5 clk = ~clk;

  // Reference model using wide native arithmetic (SV division truncates toward zero).
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  begin p = sa * sb; model = p; end
      OP_MULTU: begin p = ua * ub; model = p; end
      OP_DIV:   begin sq = sa / sb; sr = sa % sb; model = {sr[31:0], sq[31:0]}; end
      default:  begin uq = ua / ub; ur = ua % ub; model = {ur[31:0], uq[31:0]}; end
    endcase
  endfunction

  // Called at posedge+1; the next edge samples the start.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mult_op    = op;
    mult_src_a = a;
    mult_src_b = b;
    mult_start = 1'b1;
  endtask

  // Measures one operation: cycle of the write strobe (0 if no strobe occurred), busy cycles before it,
  // captured data, and the write/busy state one cycle later.
  task automatic collect(output int lat, output int busy_cnt, output logic [31:0] hi,
                         output logic [31:0] lo, output logic post_wr, output logic post_busy);
    lat = 0; busy_cnt = 0; hi = 32'd0; lo = 32'd0; post_wr = 1'b1; post_busy = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 1) mult_start = 1'b0;
      if (mult_busy) busy_cnt++;
      if (reg_file_mult_write) begin
        lat = i;
        hi  = reg_file_mult_data_high;
        lo  = reg_file_mult_data_low;
        @(posedge clk); #1;
        post_wr   = reg_file_mult_write;
        post_busy = mult_busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (mult_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b exp 0", mult_busy); end
    tests_run++; if (reg_file_mult_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b exp 0", reg_file_mult_write); end
    tests_run++; if (reg_file_mult_data_low !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h exp 0", reg_file_mult_data_low); end
    tests_run++; if (reg_file_mult_data_high !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h exp 0", reg_file_mult_data_high); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (mult_busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b exp 0", mult_busy); end
  endtask

  task automatic test_multu_max();
    int lat, bc; logic [31:0] hi, lo; logic pw, pb; logic [63:0] e;
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect(lat, bc, hi, lo, pw, pb);
    tests_run++; if (lat != LAT_MUL) begin tests_failed++; $display("FAIL multu_latency: got %0d exp %0d", lat, LAT_MUL); end
    tests_run++; if (bc != LAT_MUL) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d exp %0d", bc, LAT_MUL); end
    tests_run++; if (pw !== 1'b0) begin tests_failed++; $display("FAIL multu_strobe_width: got %b exp 0 after strobe", pw); end
    tests_run++; if (pb !== 1'b0) begin tests_failed++; $display("FAIL multu_busy_after: got %b exp 0", pb); end
    e = exp_q.pop_front();
    tests_run++; if (hi !== e[63:32]) begin tests_failed++; $display("FAIL multu_hi: got %h exp %h", hi, e[63:32]); end
    tests_run++; if (lo !== e[31:0]) begin tests_failed++; $display("FAIL multu_lo: got %h exp %h", lo, e[31:0]); end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[9];
    int lat, bc, el; logic [31:0] hi, lo; logic pw, pb; logic [63:0] e;
    vecs = '{
      '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
      '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
      '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
      '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF},
      '{OP_MULT,  32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}
    };
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back({vecs[k].hi, vecs[k].lo});
      el = vecs[k].op[1] ? LAT_DIV : LAT_MUL;
      launch(vecs[k].op, vecs[k].a, vecs[k].b);
      collect(lat, bc, hi, lo, pw, pb);
      e = exp_q.pop_front();
      tests_run++; if (lat != el) begin tests_failed++; $display("FAIL vec%0d_latency: got %0d exp %0d", k, lat, el); end
      tests_run++; if (hi !== e[63:32]) begin tests_failed++; $display("FAIL vec%0d_hi: got %h exp %h", k, hi, e[63:32]); end
      tests_run++; if (lo !== e[31:0]) begin tests_failed++; $display("FAIL vec%0d_lo: got %h exp %h", k, lo, e[31:0]); end
    end
  endtask

  // Ops issued as soon as the unit returns to IDLE, with model-generated expectations.
  task automatic test_back_to_back();
    int lat, bc, el; logic [31:0] hi, lo, a, b; logic pw, pb; logic [1:0] op; logic [63:0] e;
    for (int k = 0; k < 12; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (k % 3 == 0) b = b >> 20;
      if (op[1] && b == 32'd0) b = 32'd1;
      exp_q.push_back(model(op, a, b));
      el = op[1] ? LAT_DIV : LAT_MUL;
      launch(op, a, b);
      collect(lat, bc, hi, lo, pw, pb);
      e = exp_q.pop_front();
      tests_run++; if (lat != el) begin tests_failed++; $display("FAIL b2b%0d_latency: got %0d exp %0d", k, lat, el); end
      tests_run++; if ({hi, lo} !== e) begin tests_failed++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h exp %h", k, op, a, b, {hi, lo}, e); end
    end
  endtask

  task automatic test_ignored_start();
    int nwr, lat, ign_at; logic [31:0] hi, lo; logic [63:0] e;
    ign_at = (LAT_MUL > 5) ? 4 : 1;
    nwr = 0; lat = 0; hi = 32'd0; lo = 32'd0;
    exp_q.push_back({32'd0, 32'd30});
    launch(OP_MULTU, 32'd5, 32'd6);
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (i == 1) mult_start = 1'b0;
      if (i == ign_at) launch(OP_DIVU, 32'd9, 32'd2);
      if (i == ign_at + 1) mult_start = 1'b0;
      if (reg_file_mult_write) begin
        nwr++; lat = i; hi = reg_file_mult_data_high; lo = reg_file_mult_data_low;
      end
    end
    e = exp_q.pop_front();
    tests_run++; if (nwr != 1) begin tests_failed++; $display("FAIL ignore_write_count: got %0d exp 1", nwr); end
    tests_run++; if (lat != LAT_MUL) begin tests_failed++; $display("FAIL ignore_latency: got %0d exp %0d", lat, LAT_MUL); end
    tests_run++; if ({hi, lo} !== e) begin tests_failed++; $display("FAIL ignore_result: got %h exp %h", {hi, lo}, e); end
    tests_run++; if (mult_busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_busy_end: got %b exp 0", mult_busy); end
  endtask

  task automatic test_reset_mid_op();
    int nwr, nbusy, lat, bc; logic [31:0] hi, lo; logic pw, pb; logic [63:0] e;
    nwr = 0; nbusy = 0;
    launch(OP_MULT, 32'd3, 32'd4);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) mult_start = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if (mult_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b exp 0", mult_busy); end
    tests_run++; if (reg_file_mult_data_low !== 32'd0) begin tests_failed++; $display("FAIL rst_async_lo: got %h exp 0", reg_file_mult_data_low); end
    tests_run++; if (reg_file_mult_data_high !== 32'd0) begin tests_failed++; $display("FAIL rst_async_hi: got %h exp 0", reg_file_mult_data_high); end
    repeat (3) begin
      @(posedge clk); #1;
      if (reg_file_mult_write) nwr++;
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (reg_file_mult_write) nwr++;
      if (mult_busy) nbusy++;
    end
    tests_run++; if (nwr != 0) begin tests_failed++; $display("FAIL rst_no_write: got %0d strobes exp 0", nwr); end
    tests_run++; if (nbusy != 0) begin tests_failed++; $display("FAIL rst_stays_idle: got %0d busy cycles exp 0", nbusy); end
    exp_q.push_back({32'd1, 32'd3});
    launch(OP_DIVU, 32'd7, 32'd2);
    collect(lat, bc, hi, lo, pw, pb);
    e = exp_q.pop_front();
    tests_run++; if (lat != LAT_DIV) begin tests_failed++; $display("FAIL rst_recover_latency: got %0d exp %0d", lat, LAT_DIV); end
    tests_run++; if ({hi, lo} !== e) begin tests_failed++; $display("FAIL rst_recover_result: got %h exp %h", {hi, lo}, e); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
